// File: rtl/enc_seq_pkg.sv
// Shared types and constants for the encoder round sequencer.
// The stage-timeout logic in the top is enabled by the ENC_SEQ_TIMEOUT_EN macro.
package enc_seq_pkg;

    localparam int unsigned DefaultRounds  = 24;
    localparam int unsigned DefaultNStages = 5;
    localparam int unsigned DefaultTimeout = 255;

    localparam int unsigned STG_COLPARITY = 0;
    localparam int unsigned STG_ROTATE    = 1;
    localparam int unsigned STG_PERMUTE   = 2;
    localparam int unsigned STG_REVAL     = 3;
    localparam int unsigned STG_ADDRC     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAdvance,
        StNextRound,
        StFinish
    } seq_state_e;

    // Width of an index over n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_seq_counter.sv
// Up-counter with synchronous clear, load and increment; carry_o flags all-ones.
// Priority: clear over load over increment.
module enc_seq_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             carry_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign carry_o = &cnt_q;

endmodule

// File: rtl/enc_round_sequencer.sv
// Round/stage scheduler: issues one-hot stage starts, waits for each done, flips the
// ping-pong bank per stage. Define ENC_SEQ_TIMEOUT_EN for the per-stage wait timeout.
module enc_round_sequencer
    import enc_seq_pkg::*;
#(
    parameter int unsigned ROUNDS   = DefaultRounds,
    parameter int unsigned N_STAGES = DefaultNStages,
    parameter int unsigned TIMEOUT  = DefaultTimeout,
    localparam int unsigned StageW  = idx_width(N_STAGES),
    localparam int unsigned RoundW  = idx_width(ROUNDS)
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic [N_STAGES-1:0] stage_done_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [N_STAGES-1:0] stage_start_o,
    output logic [StageW-1:0]   stage_idx_o,
    output logic [RoundW-1:0]   round_o,
    output logic                bank_sel_o,
    output logic                err_o
);

    if (ROUNDS == 0 || N_STAGES == 0 || TIMEOUT == 0) begin : g_param_check
        $error("enc_round_sequencer: ROUNDS, N_STAGES and TIMEOUT must be at least 1");
    end

    seq_state_e state_d, state_q;
    logic       bank_d, bank_q;
    logic [StageW-1:0] stage_idx;
    logic [RoundW-1:0] round;
    logic stage_carry, round_carry;
    logic stage_clr, stage_inc, round_inc;
    logic msg_start, stage_hit, timeout_hit;
    logic last_stage, last_round;

    assign stage_hit  = stage_done_i[stage_idx];
    assign last_stage = (stage_idx == StageW'(N_STAGES - 1));
    assign last_round = (round == RoundW'(ROUNDS - 1));

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        msg_start = 1'b0;
        stage_inc = 1'b0;
        round_inc = 1'b0;
        stage_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    msg_start = 1'b1;
                    bank_d    = 1'b0;
                    stage_clr = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (stage_hit) begin
                    state_d = StAdvance;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StAdvance: begin
                bank_d    = ~bank_q;
                stage_inc = ~last_stage;
                state_d   = last_stage ? StNextRound : StIssue;
            end
            StNextRound: begin
                if (last_round) begin
                    state_d = StFinish;
                end else begin
                    round_inc = 1'b1;
                    stage_clr = 1'b1;
                    state_d   = StIssue;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
        end
    end

    // Carry guards keep the index counters from ever wrapping inside a message.
    enc_seq_counter #(.Width(StageW)) u_stage_cnt (
        .clk_i      (clk_i),
        .rst_ni     (reset_ni),
        .clr_i      (stage_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (stage_inc & ~stage_carry),
        .cnt_o      (stage_idx),
        .carry_o    (stage_carry)
    );

    enc_seq_counter #(.Width(RoundW)) u_round_cnt (
        .clk_i      (clk_i),
        .rst_ni     (reset_ni),
        .clr_i      (msg_start),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (round_inc & ~round_carry),
        .cnt_o      (round),
        .carry_o    (round_carry)
    );

`ifdef ENC_SEQ_TIMEOUT_EN
    localparam int unsigned WaitW = idx_width(TIMEOUT + 1);

    logic [WaitW-1:0] wait_cnt;
    logic             wait_carry;
    logic             err_d, err_q;

    enc_seq_counter #(.Width(WaitW)) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_ni     (reset_ni),
        .clr_i      (state_q == StIssue),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      ((state_q == StWait) & ~wait_carry),
        .cnt_o      (wait_cnt),
        .carry_o    (wait_carry)
    );

    // The TIMEOUT-th Wait cycle without a done is the last one.
    assign timeout_hit = (wait_cnt == WaitW'(TIMEOUT - 1));

    always_comb begin
        err_d = err_q;
        if (msg_start) begin
            err_d = 1'b0;
        end else if ((state_q == StWait) && !stage_hit && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        stage_start_o = '0;
        if (state_q == StIssue) begin
            stage_start_o[stage_idx] = 1'b1;
        end
    end

    assign ready_o     = (state_q == StIdle);
    assign done_o      = (state_q == StFinish);
    assign stage_idx_o = stage_idx;
    assign round_o     = round;
    assign bank_sel_o  = bank_q;

endmodule

// File: tb/tb_enc_round_sequencer.sv
// Self-checking bench: three sequencer configurations driven by a randomized stage
// responder and compared against a cycle timeline computed from the round/stage rules.
module tb_enc_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [4:0] stage_done = '0;

    always #5 clk = ~clk;

    // Default configuration: 24 rounds, 5 stages.
    logic       a_ready, a_done, a_bank, a_err;
    logic [4:0] a_ss, a_round;
    logic [2:0] a_idx;
    enc_round_sequencer u_dut_a (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .start_i       (start[0]),
        .stage_done_i  (stage_done),
        .ready_o       (a_ready),
        .done_o        (a_done),
        .stage_start_o (a_ss),
        .stage_idx_o   (a_idx),
        .round_o       (a_round),
        .bank_sel_o    (a_bank),
        .err_o         (a_err)
    );

    // Short configuration: 3 rounds, 5 stages, timeout 10.
    logic       b_ready, b_done, b_bank, b_err;
    logic [4:0] b_ss;
    logic [2:0] b_idx;
    logic [1:0] b_round;
    enc_round_sequencer #(.ROUNDS(3), .N_STAGES(5), .TIMEOUT(10)) u_dut_b (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .start_i       (start[1]),
        .stage_done_i  (stage_done),
        .ready_o       (b_ready),
        .done_o        (b_done),
        .stage_start_o (b_ss),
        .stage_idx_o   (b_idx),
        .round_o       (b_round),
        .bank_sel_o    (b_bank),
        .err_o         (b_err)
    );

    // Degenerate configuration: 1 round, 1 stage.
    logic       c_ready, c_done, c_bank, c_err;
    logic [0:0] c_ss, c_idx, c_round;
    enc_round_sequencer #(.ROUNDS(1), .N_STAGES(1)) u_dut_c (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .start_i       (start[2]),
        .stage_done_i  (stage_done[0:0]),
        .ready_o       (c_ready),
        .done_o        (c_done),
        .stage_start_o (c_ss),
        .stage_idx_o   (c_idx),
        .round_o       (c_round),
        .bank_sel_o    (c_bank),
        .err_o         (c_err)
    );

    int         sel = 0;
    logic       obs_ready, obs_done, obs_bank, obs_err;
    logic [4:0] obs_ss, obs_round;
    logic [2:0] obs_idx;

    always_comb begin
        case (sel)
            1: begin
                obs_ready = b_ready; obs_done = b_done; obs_bank = b_bank; obs_err = b_err;
                obs_ss = b_ss; obs_idx = b_idx; obs_round = {3'b0, b_round};
            end
            2: begin
                obs_ready = c_ready; obs_done = c_done; obs_bank = c_bank; obs_err = c_err;
                obs_ss = {4'b0, c_ss}; obs_idx = {2'b0, c_idx}; obs_round = {4'b0, c_round};
            end
            default: begin
                obs_ready = a_ready; obs_done = a_done; obs_bank = a_bank; obs_err = a_err;
                obs_ss = a_ss; obs_idx = a_idx; obs_round = a_round;
            end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;
    int cur_r, cur_n;
    int dly [24][5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start = '0;
        start[sel] = v;
    endtask

    task automatic select(input int i, input int r, input int n);
        sel = i;
        cur_r = r;
        cur_n = n;
        @(negedge clk);
    endtask

    task automatic set_dly(input int max_extra);
        for (int r = 0; r < 24; r++) begin
            for (int s = 0; s < 5; s++) begin
                dly[r][s] = (max_extra > 0) ? int'($urandom_range(0, max_extra)) : 0;
            end
        end
    endtask

    // One message. dly[r][s] = extra Wait cycles before stage s of round r accepts its done.
    // exp_lat: edges from start edge to Finish (-1 to skip); reset_ev: stage event to reset in.
    task automatic run_msg(input int exp_lat, input int reset_ev);
        int ev_t[$], ev_s[$], ev_r[$], ev_d[$];
        int t, k, fin, reset_at, done_at, s, at;
        logic [4:0] drv;
        t = 1;
        for (int r = 0; r < cur_r; r++) begin
            for (int i = 0; i < cur_n; i++) begin
                ev_t.push_back(t);
                ev_s.push_back(i);
                ev_r.push_back(r);
                ev_d.push_back(dly[r][i]);
                t += 3 + dly[r][i];
            end
            t += 1;
        end
        fin = t;
        reset_at = -1;
        if (reset_ev >= 0) reset_at = ev_t[reset_ev] + 1;
        k = 0;
        done_at = -1;
        check("ready_idle", obs_ready, 1);
        drive_start(1'b1);
        stage_done = 5'($urandom);
        for (int c = 1; c <= fin + 2; c++) begin
            @(negedge clk);
            if (reset_at > 0 && c == reset_at + 1) begin
                check("rst_ready", obs_ready, 1);
                check("rst_round", obs_round, 0);
                check("rst_idx", obs_idx, 0);
                check("rst_bank", obs_bank, 0);
                check("rst_stage_start", obs_ss, 0);
                check("rst_done", obs_done, 0);
                rst_n = 1'b1;
                drive_start(1'b0);
                stage_done = '0;
                return;
            end
            while (k + 1 < ev_t.size() && ev_t[k + 1] <= c) k++;
            s = ev_s[k];
            at = ev_t[k];
            check("stage_start", obs_ss, (c == at) ? 5'(1 << s) : 5'd0);
            if (c == at) begin
                check("stage_idx", obs_idx, s);
                check("round", obs_round, ev_r[k]);
            end
            if (obs_done === 1'b1 && done_at < 0) done_at = c;
            check("done", obs_done, c == fin);
            check("ready", obs_ready, c > fin);
            if (c == fin) begin
                check("bank_final", obs_bank, (cur_r * cur_n) % 2);
                check("err", obs_err, 0);
            end
            // Garbage everywhere except the awaited bit, which rises only when accepted.
            drv = 5'($urandom);
            if (c > at && c < at + 1 + ev_d[k]) begin
                drv[s] = 1'b0;
                if (s == 1 && cur_n > 3) drv[3] = 1'b1;
            end else if (c == at + 1 + ev_d[k]) begin
                drv[s] = 1'b1;
            end
            stage_done = drv;
            if (c == reset_at) rst_n = 1'b0;
            // Random mid-message starts, and start held through Finish, must be ignored.
            drive_start((c == fin) || (c < fin && $urandom_range(0, 3) == 0));
        end
        if (exp_lat >= 0) check("latency", done_at, exp_lat + 1);
        drive_start(1'b0);
        stage_done = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check("reset_ready", obs_ready, 1);
            check("reset_done", obs_done, 0);
            check("reset_ss", obs_ss, 0);
            check("reset_idx", obs_idx, 0);
            check("reset_round", obs_round, 0);
            check("reset_bank", obs_bank, 0);
            check("reset_err", obs_err, 0);
        end
        rst_n = 1'b1;

        // Defaults, every done in the first Wait cycle.
        select(0, 24, 5);
        set_dly(0);
        run_msg(384, -1);

        // 3 rounds; stage 2 returns done 7 cycles after its start (6 extra Wait cycles).
        select(1, 3, 5);
        set_dly(0);
        for (int r = 0; r < 3; r++) dly[r][2] = 6;
        run_msg(66, -1);

        // Stage 1 sees stage_done[3] for 5 Wait cycles before its own bit.
        select(0, 24, 5);
        set_dly(3);
        for (int r = 0; r < 24; r++) dly[r][1] = 5;
        run_msg(-1, -1);

        // Reset in round 5, stage 3, then a full random message.
        set_dly(2);
        run_msg(-1, 5 * 5 + 3);
        @(negedge clk);
        set_dly(2);
        run_msg(-1, -1);

        // Degenerate single round, single stage.
        select(2, 1, 1);
        set_dly(0);
        run_msg(4, -1);

`ifdef ENC_SEQ_TIMEOUT_EN
        // Stage 0 never completes on the TIMEOUT=10 instance.
        select(1, 3, 5);
        drive_start(1'b1);
        stage_done = 5'($urandom) & 5'b11110;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            drive_start(1'b0);
            stage_done = 5'($urandom) & 5'b11110;
            check("to_done", obs_done, 0);
            check("to_ready", obs_ready, c == 12);
            check("to_err", obs_err, c == 12);
        end
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        check("to_err_clr", obs_err, 0);
        check("to_issue", obs_ss, 5'b00001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enc_round_sequencer.md
# enc_round_sequencer

Top-level stage scheduler for the encoder datapath. Runs a fixed number of rounds. Each round fires every transform stage (column parity, rotate, permute, revaluate, add-round-constant) in order, with a per-stage start/done handshake. It toggles the ping-pong state-memory bank after each stage and exposes the round index for the round-constant stage. It sits above the per-stage controllers, and each stage controller sees only its own `stage_start`/`stage_done` pair.

## Interface
- `ROUNDS`, 24, rounds per message (≥1)
- `N_STAGES`, 5, transform stages per round (≥1)
- `TIMEOUT`, 255, max Wait cycles per stage (used only with the timeout feature)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin a message; sampled only in Idle
- `stage_done`  in  N_STAGES  per-stage completion; bit i is looked at only while stage i is in Wait
- `ready`  out  1  high in Idle
- `done`  out  1  one-cycle pulse when all rounds are complete
- `stage_start`  out  N_STAGES  one-hot, one-cycle start pulse
- `stage_idx`  out  $clog2(N_STAGES) (min 1)  current stage index
- `round`  out  $clog2(ROUNDS) (min 1)  current round index
- `bank_sel`  out  1  state-memory read bank; the write bank is ~bank_sel
- `err`  out  1  stage timeout flag (timeout feature only)

## Operation
- States and transitions:
  - Idle → Issue when `start`=1.
  - Issue → Wait.
  - Wait → Advance when `stage_done[stage_idx]`=1.
  - Advance → Issue when `stage_idx` < N_STAGES-1; otherwise Advance → NextRound.
  - NextRound → Issue when `round` < ROUNDS-1; otherwise NextRound → Finish.
  - Finish → Idle.
- Idle:
  - `ready`=1.
  - On `start`, clear `stage_idx`, `round` and `bank_sel` to 0 (and `err`, if the timeout feature is compiled in).
- Issue: `stage_start[stage_idx]`=1 for exactly this cycle.
- Wait: holds until `stage_done[stage_idx]`. Other `stage_done` bits are ignored.
- Advance:
  - `bank_sel` toggles.
  - `stage_idx` increments, or stays put on the last stage.
- NextRound: `round` increments and `stage_idx` clears to 0. On the last round both hold.
- Finish: `done`=1 for one cycle.
- Reset values: state=Idle, `stage_idx`=0, `round`=0, `bank_sel`=0, `err`=0, `stage_start`=0, `done`=0, `ready`=1 in the cycle after reset.
- Counter arithmetic is unsigned. Counters never wrap within a message; they are cleared explicitly.
- `bank_sel` toggles ROUNDS×N_STAGES times per message. Its final value is the parity of that product, and it is the bank holding the result.

## Timing
- Issue→Wait is unconditional, so a `stage_done` asserted in the same cycle as `stage_start` is not seen. The earliest accepted done is in the first Wait cycle.
- Minimum cost per stage is 3 cycles (Issue, Wait, Advance), plus 1 cycle per round for NextRound.
- With every done arriving in the first Wait cycle, Finish is entered exactly ROUNDS×(3×N_STAGES+1) edges after the edge that samples `start`. That is 384 edges for the defaults.
- `start` while not Idle is ignored.
- `start` held high in Finish is ignored. If it is still high in the following Idle cycle, it launches a new message.
- `reset`=0 mid-message: the block returns to Idle at that edge with all outputs at reset values. No further `stage_start` is issued.
- ROUNDS=1 or N_STAGES=1 must work. The index outputs are then constant 0.

## Configuration
- Macro: `ENC_SEQ_TIMEOUT_EN`.
- Defined:
  - A wait counter clears in Issue and increments each Wait cycle.
  - If the counter reaches TIMEOUT without the awaited `stage_done`, the block sets `err`=1 and goes to Idle; `done` is not pulsed.
  - `err` is sticky until the next accepted `start` or reset.
- Undefined: no wait counter, `err` is tied 0, and Wait holds indefinitely.

## Structure
- Shared package `enc_seq_pkg` holds:
  - the state enum: Idle, Issue, Wait, Advance, NextRound, Finish;
  - default ROUNDS, N_STAGES and TIMEOUT constants;
  - the stage-index constants STG_COLPARITY=0, STG_ROTATE=1, STG_PERMUTE=2, STG_REVAL=3, STG_ADDRC=4.
- One sub-module, `enc_seq_counter`:
  - parameterised width;
  - controls: inc, sync clear, load;
  - output: carry-out at all-ones.
- `enc_seq_counter` is instantiated for `round`, `stage_idx` and (under the macro) the wait counter.

## Test plan
- **Defaults, instant done:** pulse `start`; the stage model returns `stage_done` in the first Wait cycle.
  - `done` arrives 384 edges after the start edge.
  - 120 `stage_start` pulses occur, one-hot, in order 0..4 repeating.
  - `round` runs 0..23; final `bank_sel`=0.
- **ROUNDS=3, N_STAGES=5, stage 2 delays done by 7 cycles:**
  - `done` arrives 3×16+3×6 = 66 edges after the start edge.
  - No second `stage_start` is issued while stage 2 is waiting.
- **Wrong-stage done:** in Wait for stage 1, assert `stage_done[3]` for 5 cycles and then `stage_done[1]`.
  - Advance happens only after bit 1.
  - `start` pulsed mid-message has no effect.
- **Reset mid-message:** drive `reset`=0 in round 5, stage 3.
  - Next cycle: `ready`=1, `round`=0, `bank_sel`=0, `stage_start`=0.
  - A new `start` runs a full message correctly.
- **Timeout (`ENC_SEQ_TIMEOUT_EN`, TIMEOUT=10):** stage 0 never completes.
  - `err`=1 and the block is in Idle after 10 Wait cycles; `done` never pulses.
  - The next `start` clears `err`.
- **Degenerate ROUNDS=1, N_STAGES=1:** `done` arrives 4 edges after start; `bank_sel`=1 at finish.
